// File: rtl/mux_2to1_l2_if.sv
// mux_2to1_l2_if: lane/bus bundle for the L2 2-to-1 lane-merge stage.
//   master : drives the two input lanes (in0/in1 + valid bits), observes outputs
//   slave  : the merge stage; consumes lanes, drives data_out/valid_bit_out/
//            lane_out, per-lane full flags and the sticky overflow flag
interface mux_2to1_l2_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in0;
  logic [DATA_W-1:0] in1;
  logic              valid_bit0;
  logic              valid_bit1;
  logic [DATA_W-1:0] data_out;
  logic              valid_bit_out;
  logic              lane_out;
  logic              full0;
  logic              full1;
  logic              overflow;

  modport master (
    output in0, in1, valid_bit0, valid_bit1,
    input  data_out, valid_bit_out, lane_out, full0, full1, overflow
  );

  modport slave (
    input  in0, in1, valid_bit0, valid_bit1,
    output data_out, valid_bit_out, lane_out, full0, full1, overflow
  );
endinterface

// File: rtl/mux_2to1_l2.sv
// mux_2to1_l2: second-level lane merge. Each of the two incoming byte lanes is
// buffered in a DEPTH-entry FIFO; the FIFOs are drained round-robin onto one
// registered byte stream tagged with its source lane.
//
// Ports:
//   clk_4f : clock, rising edge
//   reset  : asynchronous reset, active-high
//   bus    : mux_2to1_l2_if.slave
//            in0/in1, valid_bit0/1      lane bytes and their valid bits
//            data_out, valid_bit_out    merged byte and valid (registered)
//            lane_out                   source lane of data_out (registered)
//            full0/full1                lane FIFO holds DEPTH entries
//            overflow                   sticky: a lane write was dropped
//
// Optional feature macro: IDLE_FILL_EN
//   defined   : when idle, data_out=IDLE_BYTE and lane_out=0; same after reset
//   undefined : data_out/lane_out hold their last value when idle; reset to 0
module mux_2to1_l2 #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
`ifdef IDLE_FILL_EN
  , parameter logic [DATA_W-1:0] IDLE_BYTE = 8'hBC
`endif
) (
  input logic          clk_4f,
  input logic          reset,
  mux_2to1_l2_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
`ifdef IDLE_FILL_EN
  localparam logic [DATA_W-1:0] RST_DATA = IDLE_BYTE;
`else
  localparam logic [DATA_W-1:0] RST_DATA = '0;
`endif

  logic [DATA_W-1:0] mem_q [2][DEPTH];
  logic [DATA_W-1:0] mem_d [2][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [2], wr_ptr_d [2];
  logic [PTR_W-1:0]  rd_ptr_q [2], rd_ptr_d [2];
  logic [CNT_W-1:0]  count_q [2], count_d [2];
  logic              turn_q, turn_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_q, valid_d;
  logic              lane_q, lane_d;
  logic              overflow_q, overflow_d;

  logic [DATA_W-1:0] lane_in [2];
  logic              lane_vld [2];
  logic              nonempty [2];
  logic              pop_any;
  logic              pop_lane;
  logic              push [2];
  logic              pop [2];

  assign lane_in[0]  = bus.in0;
  assign lane_in[1]  = bus.in1;
  assign lane_vld[0] = bus.valid_bit0;
  assign lane_vld[1] = bus.valid_bit1;
  assign nonempty[0] = (count_q[0] != '0);
  assign nonempty[1] = (count_q[1] != '0);

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    turn_d     = turn_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    lane_d     = lane_q;
    overflow_d = overflow_q;
    pop_any    = 1'b0;
    pop_lane   = 1'b0;
    push       = '{1'b0, 1'b0};
    pop        = '{1'b0, 1'b0};

    // Arbitration looks only at registered counts, so a byte pushed this edge
    // is never popped in the same edge.
    if (nonempty[turn_q]) begin
      pop_any  = 1'b1;
      pop_lane = turn_q;
    end else if (nonempty[!turn_q]) begin
      pop_any  = 1'b1;
      pop_lane = !turn_q;
    end

    if (pop_any) begin
      data_out_d         = mem_q[pop_lane][rd_ptr_q[pop_lane]];
      valid_d            = 1'b1;
      lane_d             = pop_lane;
      turn_d             = !pop_lane;
      pop[pop_lane]      = 1'b1;
      rd_ptr_d[pop_lane] = rd_ptr_q[pop_lane] + PTR_W'(1);
    end else begin
`ifdef IDLE_FILL_EN
      data_out_d = IDLE_BYTE;
      lane_d     = 1'b0;
`endif
    end

    // Full check uses the pre-pop count: a byte arriving at a full FIFO is
    // dropped even if that FIFO is being popped on the same edge.
    for (int l = 0; l < 2; l++) begin
      if (lane_vld[l]) begin
        if (count_q[l] == FULL_CNT) begin
          overflow_d = 1'b1;
        end else begin
          push[l]                 = 1'b1;
          mem_d[l][wr_ptr_q[l]]   = lane_in[l];
          wr_ptr_d[l]             = wr_ptr_q[l] + PTR_W'(1);
        end
      end
      count_d[l] = count_q[l] + CNT_W'(push[l]) - CNT_W'(pop[l]);
    end
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      for (int l = 0; l < 2; l++) begin
        for (int e = 0; e < DEPTH; e++) begin
          mem_q[l][e] <= '0;
        end
        wr_ptr_q[l] <= '0;
        rd_ptr_q[l] <= '0;
        count_q[l]  <= '0;
      end
      turn_q     <= 1'b0;
      data_out_q <= RST_DATA;
      valid_q    <= 1'b0;
      lane_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      turn_q     <= turn_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      lane_q     <= lane_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.data_out      = data_out_q;
  assign bus.valid_bit_out = valid_q;
  assign bus.lane_out      = lane_q;
  assign bus.full0         = (count_q[0] == FULL_CNT);
  assign bus.full1         = (count_q[1] == FULL_CNT);
  assign bus.overflow      = overflow_q;

endmodule
